// File: rtl/vend_pkg.sv
// Shared codes and types for the vending machine change dispenser.
// Change codes, FSM state encoding and hopper selection.
package vend_pkg;

    localparam logic [1:0] CHG_NONE = 2'b00;
    localparam logic [1:0] CHG_5    = 2'b01;
    localparam logic [1:0] CHG_10   = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT_SENSE,
        GAP,
        FAULT
    } state_t;

    typedef enum logic {
        SEL_5,
        SEL_10
    } coin_sel_t;

endpackage

// File: rtl/vend_pend_counter.sv
// Saturating pending-coin counter: +1, +2 and -1 in one cycle combine into a net
// update; clip flags an update that had to be held at the maximum.
module vend_pend_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc1,
    input  logic             inc2,
    input  logic             dec1,
    output logic [CNT_W-1:0] cnt,
    output logic             clip
);

    localparam logic [CNT_W+1:0] ONE  = {{(CNT_W+1){1'b0}}, 1'b1};
    localparam logic [CNT_W+1:0] TWO  = {{CNT_W{1'b0}}, 2'b10};
    localparam logic [CNT_W+1:0] MAXV = {2'b00, {CNT_W{1'b1}}};

    logic [CNT_W+1:0] sum;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        sum = {2'b00, cnt};
        if (inc1) sum = sum + ONE;
        if (inc2) sum = sum + TWO;
        // Decrement is applied to the widened sum so a capture in the same cycle nets out
        if (dec1 && sum != '0) sum = sum - ONE;
        clip  = (sum > MAXV);
        cnt_d = clip ? MAXV[CNT_W-1:0] : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else      cnt <= cnt_d;
    end

endmodule

// File: rtl/vend_change_dispenser.sv
// Change payout controller: queues owed coins from the vending FSM and fires the
// 5 rs / 10 rs hopper solenoids one coin at a time, confirming each drop.
module vend_change_dispenser
    import vend_pkg::*;
#(
    parameter int PULSE_CYCLES   = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       change,
    input  logic             coin_sense,
    input  logic             hopper5_empty,
    input  logic             hopper10_empty,
    input  logic             fault_clr,
    output logic             coin5_drive,
    output logic             coin10_drive,
    output logic             busy,
    output logic             fault,
    output logic             overflow,
    output logic [CNT_W-1:0] pend5,
    output logic [CNT_W-1:0] pend10
);

    localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES)
                        ? ((PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES : TIMEOUT_CYCLES)
                        : ((GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES);
    localparam int TW = $clog2(TMAX + 1);

    localparam logic [TW-1:0] T_PULSE   = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] T_GAP     = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] T_TIMEOUT = TW'(TIMEOUT_CYCLES - 1);

    state_t    state_q, state_d;
    coin_sel_t sel_q, sel_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic      seen_q, seen_d;
    logic      subst, dec5, dec10;
    logic      c5_q, c10_q;
    logic      clip5, clip10;
    logic      have5, have10;

    assign have5  = (pend5 != '0);
    assign have10 = (pend10 != '0);

    vend_pend_counter #(.CNT_W(CNT_W)) u_pend5 (
        .clk  (clk),
        .rst  (rst),
        .inc1 (change == CHG_5),
        .inc2 (subst),
        .dec1 (dec5),
        .cnt  (pend5),
        .clip (clip5)
    );

    vend_pend_counter #(.CNT_W(CNT_W)) u_pend10 (
        .clk  (clk),
        .rst  (rst),
        .inc1 (change == CHG_10),
        .inc2 (1'b0),
        .dec1 (dec10 | subst),
        .cnt  (pend10),
        .clip (clip10)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        tmr_d   = tmr_q;
        seen_d  = seen_q;
        subst   = 1'b0;
        dec5    = 1'b0;
        dec10   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (have10 && !hopper10_empty) begin
                    state_d = DRIVE;
                    sel_d   = SEL_10;
                    tmr_d   = T_PULSE;
                    seen_d  = 1'b0;
                end else if (have10 && !hopper5_empty) begin
                    // 10 rs hopper is dry: owe two 5 rs coins instead
                    subst = 1'b1;
                end else if (have5 && !hopper5_empty) begin
                    state_d = DRIVE;
                    sel_d   = SEL_5;
                    tmr_d   = T_PULSE;
                    seen_d  = 1'b0;
                end else if (have5 || have10) begin
                    state_d = FAULT;
                end
            end
            DRIVE: begin
                if (coin_sense) seen_d = 1'b1;
                if (tmr_q == '0) begin
                    state_d = WAIT_SENSE;
                    tmr_d   = T_TIMEOUT;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            WAIT_SENSE: begin
                if (seen_q || coin_sense) begin
                    dec5    = (sel_q == SEL_5);
                    dec10   = (sel_q == SEL_10);
                    state_d = GAP;
                    tmr_d   = T_GAP;
                end else if (tmr_q == '0) begin
                    state_d = FAULT;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            GAP: begin
                if (tmr_q == '0) state_d = IDLE;
                else             tmr_d   = tmr_q - 1'b1;
            end
            FAULT: begin
                if (fault_clr) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            sel_q    <= SEL_5;
            tmr_q    <= '0;
            seen_q   <= 1'b0;
            c5_q     <= 1'b0;
            c10_q    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            tmr_q    <= tmr_d;
            seen_q   <= seen_d;
            c5_q     <= (state_d == DRIVE) && (sel_d == SEL_5);
            c10_q    <= (state_d == DRIVE) && (sel_d == SEL_10);
            overflow <= overflow | clip5 | clip10;
        end
    end

    assign coin5_drive  = c5_q;
    assign coin10_drive = c10_q;
    assign busy  = (state_q == DRIVE) || (state_q == WAIT_SENSE) || (state_q == GAP);
    assign fault = (state_q == FAULT);

endmodule
